// File: rtl/mac_lane_array.sv
// -----------------------------------------------------------------------------
// mac_lane_array
//
// Purpose:
//   NUM_LANES parallel multiply-accumulate lanes that share one unsigned
//   activation stream. Each lane has its own signed weight and bias. After
//   VEC_LEN accepted beats the accumulators are arithmetically shifted right by
//   SHIFT, saturated to a signed DATA_WIDTH value and presented on out_data
//   until the consumer takes them.
//
// Configuration macro:
//   MAC_LANE_ARRAY_RELU_EN - when defined, negative saturated lane results are
//                            output as zero (ReLU after requantisation).
//
// Parameters:
//   DATA_WIDTH - activation / weight / output element width
//   NUM_LANES  - number of MAC lanes
//   ACC_WIDTH  - per-lane signed accumulator width (must exceed 2*DATA_WIDTH+1)
//   VEC_LEN    - accepted beats per result vector (>= 1)
//   SHIFT      - requantisation arithmetic right shift (0..ACC_WIDTH-1)
//
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begin a new vector (honoured in IDLE, or with the output
//                   handshake for back-to-back vectors)
//   bias       in   per-lane signed bias, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   in_valid   in   activation/weight beat present
//   in_ready   out  beat accepted this cycle when in_valid is high
//   in_data    in   unsigned activation broadcast to all lanes
//   weight     in   per-lane signed weight, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  out_data holds a completed vector
//   out_ready  in   consumer accepts out_data
//   out_data   out  per-lane requantised signed result, same packing as weight
//   busy       out  high while accumulating or presenting a result
// -----------------------------------------------------------------------------
module mac_lane_array #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int VEC_LEN    = 784,
    parameter int SHIFT      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_LANES*ACC_WIDTH-1:0]  bias,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] weight,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            busy
);

    localparam int CNT_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PROD_W   = 2 * DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_bias;
    logic             beat_acc;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are decoded from state only, so in_ready never
    // depends on in_valid and out_valid never depends on out_ready.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_bias = 1'b0;
        beat_acc  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_bias = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    beat_acc = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    // A start coinciding with the output handshake chains
                    // straight into the next vector without an idle cycle.
                    if (start) begin
                        load_bias = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_ACCUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Lanes
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] w_lane;
            logic signed [PROD_W-1:0]     act_ext;
            logic signed [PROD_W-1:0]     w_ext;
            logic signed [PROD_W-1:0]     prod;
            logic signed [ACC_WIDTH-1:0]  prod_ext;
            logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
            logic signed [ACC_WIDTH-1:0]  shifted;
            logic                         fits;
            logic [DATA_WIDTH-1:0]        sat;
            logic [DATA_WIDTH-1:0]        lane_res;

            assign w_lane = weight[gi*DATA_WIDTH +: DATA_WIDTH];

            // Both operands are widened to the product width up front so the
            // signed multiply is exact: the activation is zero-extended
            // (unsigned), the weight sign-extended.
            assign act_ext  = $signed({{(DATA_WIDTH+1){1'b0}}, in_data});
            assign w_ext    = {{(DATA_WIDTH+1){w_lane[DATA_WIDTH-1]}}, w_lane};
            assign prod     = act_ext * w_ext;
            assign prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

            always_comb begin
                acc_d = acc_q;
                if (load_bias) begin
                    acc_d = $signed(bias[gi*ACC_WIDTH +: ACC_WIDTH]);
                end else if (beat_acc) begin
                    acc_d = acc_q + prod_ext;   // wraps modulo 2^ACC_WIDTH
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            // The shifted value fits in DATA_WIDTH signed bits exactly when
            // every bit from the output sign position upward is identical.
            assign shifted = acc_q >>> SHIFT;
            assign fits    = (&shifted[ACC_WIDTH-1:DATA_WIDTH-1]) |
                             (~|shifted[ACC_WIDTH-1:DATA_WIDTH-1]);
            assign sat     = fits ? shifted[DATA_WIDTH-1:0]
                                  : {shifted[ACC_WIDTH-1],
                                     {(DATA_WIDTH-1){~shifted[ACC_WIDTH-1]}}};

`ifdef MAC_LANE_ARRAY_RELU_EN
            assign lane_res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
            assign lane_res = sat;
`endif

            // Zero outside OUTPUT so the bus is quiet in reset and idle.
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                (state_q == S_OUTPUT) ? lane_res : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mac_lane_array.sv
// -----------------------------------------------------------------------------
// tb_mac_lane_array
//
// Directed testbench for mac_lane_array. Two instances share all inputs: one
// with SHIFT=0 and one with SHIFT=2 (NUM_LANES=4, DATA_WIDTH=8, ACC_WIDTH=32,
// VEC_LEN=4). Expected lane values are hand-computed constants; when
// MAC_LANE_ARRAY_RELU_EN is defined negative expectations become zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_lane_array;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] bias;
    logic         in_valid;
    logic [7:0]   in_data;
    logic [31:0]  weight;
    logic         out_ready;

    logic         in_ready0, out_valid0, busy0;
    logic [31:0]  out_data0;
    logic         in_ready2, out_valid2, busy2;
    logic [31:0]  out_data2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_lane_array #(
        .DATA_WIDTH(8), .NUM_LANES(4), .ACC_WIDTH(32), .VEC_LEN(4), .SHIFT(0)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .weight(weight), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .busy(busy0)
    );

    mac_lane_array #(
        .DATA_WIDTH(8), .NUM_LANES(4), .ACC_WIDTH(32), .VEC_LEN(4), .SHIFT(2)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .weight(weight), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .busy(busy2)
    );

    // Expected-value model for the optional ReLU stage.
    function automatic int rl(input int v);
`ifdef MAC_LANE_ARRAY_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [127:0] pack_bias(input int b0, input int b1,
                                               input int b2, input int b3);
        return {32'(b3), 32'(b2), 32'(b1), 32'(b0)};
    endfunction

    function automatic logic [31:0] pack_w(input int w0, input int w1,
                                           input int w2, input int w3);
        return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] b);
        start = 1'b1;
        bias  = b;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic v, input logic [7:0] d, input logic [31:0] w);
        in_valid = v;
        in_data  = d;
        weight   = w;
        step();
        in_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0 ||
            out_data0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b data=%h required 0/0/0/0",
                     in_ready0, out_valid0, busy0, out_data0);
        end
        reset = 1'b0;
        step();
        // Beats in IDLE must not be accepted.
        in_valid = 1'b1;
        step();
        n_checks++;
        if (in_ready0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_accept: got rdy=%b busy=%b required 0/0", in_ready0, busy0);
        end
        in_valid = 1'b0;
        $display("reset: done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_saturation();
        int e0 [4] = '{127, -128, 127, -128};
        int e2 [4] = '{127, -128, 127, -128};
        do_start(pack_bias(0, 0, 0, 0));
        for (int b = 0; b < 4; b++) beat(1'b1, 8'd255, pack_w(1, -1, 127, -128));
        n_checks++;
        if (out_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_out_valid: got %b required 1", out_valid0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (int'($signed(out_data0[i*8 +: 8])) !== rl(e0[i])) begin
                n_fail++;
                $display("FAIL sat_shift0 lane %0d: got %0d required %0d",
                         i, $signed(out_data0[i*8 +: 8]), rl(e0[i]));
            end
            n_checks++;
            if (int'($signed(out_data2[i*8 +: 8])) !== rl(e2[i])) begin
                n_fail++;
                $display("FAIL sat_shift2 lane %0d: got %0d required %0d",
                         i, $signed(out_data2[i*8 +: 8]), rl(e2[i]));
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("saturation: vector out %h / %h", out_data0, out_data2);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_basic();
        int e0 [4] = '{34, 24, 24, 19};
        int e2 [4] = '{8, 6, 6, 4};
        do_start(pack_bias(10, 0, 0, -5));
        n_checks++;
        if (in_ready0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_accum_state: got rdy=%b busy=%b required 1/1", in_ready0, busy0);
        end
        for (int b = 0; b < 3; b++) beat(1'b1, 8'd2, pack_w(3, 3, 3, 3));
        n_checks++;
        if (out_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b required 0", out_valid0);
        end
        beat(1'b1, 8'd2, pack_w(3, 3, 3, 3));
        n_checks++;
        if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: got vld=%b rdy=%b required 1/0", out_valid0, in_ready0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (int'($signed(out_data0[i*8 +: 8])) !== rl(e0[i])) begin
                n_fail++;
                $display("FAIL basic_shift0 lane %0d: got %0d required %0d",
                         i, $signed(out_data0[i*8 +: 8]), rl(e0[i]));
            end
            n_checks++;
            if (int'($signed(out_data2[i*8 +: 8])) !== rl(e2[i])) begin
                n_fail++;
                $display("FAIL basic_shift2 lane %0d: got %0d required %0d",
                         i, $signed(out_data2[i*8 +: 8]), rl(e2[i]));
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_to_idle: got vld=%b busy=%b required 0/0", out_valid0, busy0);
        end
        $display("basic: vector out %h / %h", out_data0, out_data2);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_gaps();
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int e0 [4] = '{34, 24, 24, 19};
        do_start(pack_bias(10, 0, 0, -5));
        for (int b = 0; b < 7; b++) begin
            n_checks++;
            if (out_valid0 !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps_early_valid beat %0d: got %b required 0", b, out_valid0);
            end
            // Idle beats carry junk that must not be accumulated.
            beat(pat[b], pat[b] ? 8'd2 : 8'd99, pat[b] ? pack_w(3, 3, 3, 3) : pack_w(50, 50, 50, 50));
        end
        n_checks++;
        if (out_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_valid: got %b required 1", out_valid0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (int'($signed(out_data0[i*8 +: 8])) !== rl(e0[i])) begin
                n_fail++;
                $display("FAIL gaps lane %0d: got %0d required %0d",
                         i, $signed(out_data0[i*8 +: 8]), rl(e0[i]));
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("gaps: vector out %h", out_data0);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_backpressure();
        int e0 [4] = '{34, 24, 24, 19};
        do_start(pack_bias(10, 0, 0, -5));
        for (int b = 0; b < 4; b++) beat(1'b1, 8'd2, pack_w(3, 3, 3, 3));
        in_valid = 1'b1;
        in_data  = 8'd255;
        weight   = pack_w(127, 127, 127, 127);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_ctrl cycle %0d: got vld=%b rdy=%b required 1/0",
                         c, out_valid0, in_ready0);
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (int'($signed(out_data0[i*8 +: 8])) !== rl(e0[i])) begin
                    n_fail++;
                    $display("FAIL hold_data cycle %0d lane %0d: got %0d required %0d",
                             c, i, $signed(out_data0[i*8 +: 8]), rl(e0[i]));
                end
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got vld=%b busy=%b rdy=%b required 0/0/0",
                     out_valid0, busy0, in_ready0);
        end
        in_valid = 1'b0;
        $display("backpressure: vector out %h", e0[0]);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_mid_reset();
        do_start(pack_bias(10, 0, 0, -5));
        beat(1'b1, 8'd2, pack_w(3, 3, 3, 3));
        beat(1'b1, 8'd2, pack_w(3, 3, 3, 3));
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || busy0 !== 1'b0 ||
            out_data0 !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got rdy=%b vld=%b busy=%b data=%h required 0/0/0/0",
                     in_ready0, out_valid0, busy0, out_data0);
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: got busy=%b vld=%b required 0/0", busy0, out_valid0);
        end
        do_start(pack_bias(0, 0, 0, 0));
        for (int b = 0; b < 4; b++) beat(1'b1, 8'd2, pack_w(3, 3, 3, 3));
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (int'($signed(out_data0[i*8 +: 8])) !== 24) begin
                n_fail++;
                $display("FAIL midreset_result lane %0d: got %0d required 24",
                         i, $signed(out_data0[i*8 +: 8]));
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("mid_reset: vector out %h", out_data0);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_back_to_back();
        int e0 [4] = '{104, -92, 12, 17};
        int e2 [4] = '{26, -23, 3, 4};
        do_start(pack_bias(10, 0, 0, -5));
        for (int b = 0; b < 4; b++) beat(1'b1, 8'd2, pack_w(3, 3, 3, 3));
        n_checks++;
        if (int'($signed(out_data0[7:0])) !== 34) begin
            n_fail++;
            $display("FAIL b2b_first lane 0: got %0d required 34", $signed(out_data0[7:0]));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        bias      = pack_bias(100, -100, 0, 1);
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        n_checks++;
        if (in_ready0 !== 1'b1 || busy0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_chain: got rdy=%b busy=%b vld=%b required 1/1/0",
                     in_ready0, busy0, out_valid0);
        end
        for (int b = 0; b < 4; b++) begin
            // A start mid-vector with a different bias must be ignored.
            start = (b == 1);
            bias  = (b == 1) ? pack_bias(1000, 1000, 1000, 1000) : pack_bias(100, -100, 0, 1);
            beat(1'b1, 8'd1, pack_w(1, 2, 3, 4));
        end
        start = 1'b0;
        n_checks++;
        if (out_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_valid: got %b required 1", out_valid0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (int'($signed(out_data0[i*8 +: 8])) !== rl(e0[i])) begin
                n_fail++;
                $display("FAIL b2b_shift0 lane %0d: got %0d required %0d",
                         i, $signed(out_data0[i*8 +: 8]), rl(e0[i]));
            end
            n_checks++;
            if (int'($signed(out_data2[i*8 +: 8])) !== rl(e2[i])) begin
                n_fail++;
                $display("FAIL b2b_shift2 lane %0d: got %0d required %0d",
                         i, $signed(out_data2[i*8 +: 8]), rl(e2[i]));
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b required 0", busy0);
        end
        $display("back_to_back: vector out %h / %h", out_data0, out_data2);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        weight    = '0;
        out_ready = 1'b0;
        test_reset();
        test_saturation();
        test_basic();
        test_gaps();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_lane_array.md
MAC_LANE_ARRAY -- requirements
Module: mac_lane_array

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of input activation (unsigned), weight (signed) and output element (signed).
REQ-002 Parameter NUM_LANES, default 4: number of parallel MAC lanes sharing one activation stream.
REQ-003 Parameter ACC_WIDTH, default 32: per-lane signed accumulator width.
REQ-004 Parameter VEC_LEN, default 784: accepted input beats per result vector, >=1.
REQ-005 Parameter SHIFT, default 8: arithmetic right shift applied at requantisation, 0..ACC_WIDTH-1.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  begin a new vector; honoured only in IDLE.
REQ-009 bias  input  NUM_LANES*ACC_WIDTH  per-lane signed bias, lane i at [i*ACC_WIDTH +: ACC_WIDTH], sampled on accepted start.
REQ-010 in_valid  input  1  activation/weight beat present.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 in_data  input  DATA_WIDTH  unsigned activation, broadcast to all lanes.
REQ-013 weight  input  NUM_LANES*DATA_WIDTH  per-lane signed weight, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 out_valid  output  1  out_data holds a completed vector.
REQ-015 out_ready  input  1  consumer accepts out_data.
REQ-016 out_data  output  NUM_LANES*DATA_WIDTH  per-lane requantised signed result, same lane packing as weight.
REQ-017 busy  output  1  high in ACCUM or OUTPUT.

Function
REQ-018 FSM SHALL have states IDLE, ACCUM, OUTPUT; encoding free.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 loads acc[i]<=bias[i], beat counter<=0, next state ACCUM.
REQ-020 ACCUM: in_ready=1; a beat is accepted when in_valid&&in_ready; cycles without in_valid leave acc and counter unchanged.
REQ-021 Per accepted beat acc[i] <= acc[i] + signed({1'b0,in_data})*weight[i], product sign-extended to ACC_WIDTH, sum wraps modulo 2^ACC_WIDTH.
REQ-022 Accepting beat number VEC_LEN (counter==VEC_LEN-1) SHALL move to OUTPUT; out_valid asserts the next cycle (1-cycle latency from last beat).
REQ-023 OUTPUT: in_ready=0; out_data lane i = saturate(acc[i] >>> SHIFT) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; held stable while out_valid&&!out_ready.
REQ-024 out_valid&&out_ready SHALL return to IDLE; if start=1 in that same cycle, SHALL instead load bias and enter ACCUM directly (back-to-back vectors, no idle cycle).
REQ-025 start in ACCUM or OUTPUT (other than REQ-024) SHALL be ignored.
REQ-026 out_valid SHALL NOT depend combinationally on out_ready; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, all acc to 0, counter to 0, in_ready=0, out_valid=0, busy=0, out_data=0, including mid-ACCUM or mid-OUTPUT.
REQ-028 After reset deassertion, first operation SHALL require a fresh start; no partial sums retained.

Configuration
REQ-029 Macro MAC_LANE_ARRAY_RELU_EN defined: each lane's saturated result below 0 SHALL be output as 0 (ReLU after requantisation).
REQ-030 Macro undefined: saturated signed result output unchanged, negative values preserved.

Verification (NUM_LANES=4, DATA_WIDTH=8, ACC_WIDTH=32, VEC_LEN=4, SHIFT=0 unless noted)
REQ-031 bias=0, 4 beats in_data=255, weights {1,-1,127,-128} -> acc {1020,-1020,129540,-130560}, out_data {127,-128,127,-128}; with RELU_EN {127,0,127,0}.
REQ-032 bias={10,0,0,-5}, 4 beats in_data=2 weights all 3 -> out_data {34,24,24,19}, out_valid exactly 1 cycle after 4th beat; SHIFT=2 -> {8,6,6,4}.
REQ-033 in_valid toggled 1,0,0,1,1,0,1 -> only 4 accepted beats counted, result identical to REQ-032.
REQ-034 out_ready held 0 for 5 cycles in OUTPUT, in_valid=1 throughout -> out_data stable, in_ready=0, acc unchanged; out_ready=1 -> IDLE next cycle.
REQ-035 reset pulsed after 2 accepted beats -> next cycle IDLE, out_valid=0, busy=0; new start with bias=0 and REQ-032 stimulus yields {24,24,24,24}.
REQ-036 start=1 in the out_valid&&out_ready cycle -> ACCUM next cycle with new bias, in_ready=1, no IDLE cycle; second vector correct.
